// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low hex glyphs, blank anode word, capture types.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package seg7_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG7_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG7_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG7_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG7_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG7_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG7_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG7_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG7_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG7_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG7_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG7_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG7_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG7_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG7_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG7_HEX_F = 7'b0001110;

    localparam logic [7:0] AN_BLANK  = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_STABLE,
        ST_COMMIT,
        ST_HOLD
    } cap_state_t;

    // One registered snapshot of the display pins
    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } pins_t;

    // Number of anodes driven low (active)
    function automatic logic [3:0] an_low_count(input logic [7:0] an);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~an[i]};
        end
        return n;
    endfunction

    // Index of the highest low anode; only meaningful when exactly one is low
    function automatic logic [2:0] an_low_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Maps an active-low segment pattern back to its hex nibble; valid=0 for non-hex glyphs.
// Latency: combinational.
// Backpressure: none.
import seg7_pkg::*;

module seg7_pattern_decoder (
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    // Exact inverse of the driver glyph table; anything else is illegal
    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG7_HEX_0: nibble = 4'h0;
            SEG7_HEX_1: nibble = 4'h1;
            SEG7_HEX_2: nibble = 4'h2;
            SEG7_HEX_3: nibble = 4'h3;
            SEG7_HEX_4: nibble = 4'h4;
            SEG7_HEX_5: nibble = 4'h5;
            SEG7_HEX_6: nibble = 4'h6;
            SEG7_HEX_7: nibble = 4'h7;
            SEG7_HEX_8: nibble = 4'h8;
            SEG7_HEX_9: nibble = 4'h9;
            SEG7_HEX_A: nibble = 4'hA;
            SEG7_HEX_B: nibble = 4'hB;
            SEG7_HEX_C: nibble = 4'hC;
            SEG7_HEX_D: nibble = 4'hD;
            SEG7_HEX_E: nibble = 4'hE;
            SEG7_HEX_F: nibble = 4'hF;
            default:    valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Rebuilds the 32-bit displayed word from multiplexed active-low seg/an lines.
// Latency: pins stable from edge E0 commit on E0+STABLE_CYCLES+1; frame_valid on the completing commit.
// Backpressure: none; receive-only monitor, pins sampled every cycle.
import seg7_pkg::*;

module seven_segment_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [7:0]  an,
    output logic [31:0] number,
    output logic        frame_valid,
    output logic [7:0]  digit_seen,
    output logic        seg_error,
    output logic        an_error
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    pins_t            pins_in;
    pins_t            smp;
    logic             change;
    logic [CNT_W-1:0] stab_cnt;
    cap_state_t       state;
    cap_state_t       state_nxt;

    logic             dec_vld;
    logic [3:0]       dec_nib;
    logic [3:0]       low_cnt;
    logic [2:0]       low_idx;

    logic             commit;
    logic             do_write;
    logic             set_seg_err;
    logic             set_an_err;
    logic [7:0]       seen_nxt;
    logic [31:0]      shadow;
    logic [31:0]      shadow_nxt;

    assign pins_in = '{an: an, seg: seg};

    // Change detect; an unknown compare falls to the else branch, so X never builds stability
    always_comb begin
        change = 1'b1;
        if (pins_in == smp) begin
            change = 1'b0;
        end
    end

    // Input register and saturating stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            smp      <= '{an: AN_BLANK, seg: SEG_BLANK};
            stab_cnt <= '0;
        end else begin
            smp <= pins_in;
            if (change) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CNT_SAT) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

    // Dwell FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dwell FSM next state: one commit per dwell; a change right at commit re-arms immediately
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (change) state_nxt = ST_WAIT_STABLE;
            ST_WAIT_STABLE: if (!change && stab_cnt == CNT_LAST) state_nxt = ST_COMMIT;
            ST_COMMIT:      state_nxt = change ? ST_WAIT_STABLE : ST_HOLD;
            ST_HOLD:        if (change) state_nxt = ST_WAIT_STABLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    seg7_pattern_decoder u_dec (
        .seg    (smp.seg),
        .valid  (dec_vld),
        .nibble (dec_nib)
    );

    assign low_cnt = an_low_count(smp.an);
    assign low_idx = an_low_index(smp.an);

    // FSM outputs: classify the held sample while in COMMIT and pre-merge the nibble
    always_comb begin
        commit      = (state == ST_COMMIT);
        do_write    = commit && (low_cnt == 4'd1) && dec_vld;
        set_seg_err = commit && (low_cnt == 4'd1) && !dec_vld;
        set_an_err  = commit && (low_cnt > 4'd1);
        seen_nxt    = digit_seen | (8'd1 << low_idx);
        shadow_nxt  = shadow;
        shadow_nxt[{low_idx, 2'b00} +: 4] = dec_nib;
    end

    // Shadow/frame assembly and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            number      <= '0;
            frame_valid <= 1'b0;
            digit_seen  <= '0;
            seg_error   <= 1'b0;
            an_error    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (set_seg_err) begin
                seg_error <= 1'b1;
            end
            if (set_an_err) begin
                an_error <= 1'b1;
            end
            if (do_write) begin
                shadow <= shadow_nxt;
                if (seen_nxt == 8'hFF) begin
                    number      <= shadow_nxt;
                    frame_valid <= 1'b1;
                    digit_seen  <= '0;
                end else begin
                    digit_seen <= seen_nxt;
                end
            end
        end
    end

endmodule
